// File: rtl/pwls_pkg.sv
// Shared definitions for the pwls channel: register map, command bits, writer FSM states.
package pwls_pkg;

  localparam int CHANNEL_MODE_BITS = 3;

  localparam logic [3:0] PWLS_REG_MANT_LO  = 4'd0;
  localparam logic [3:0] PWLS_REG_MANT_HI  = 4'd1;
  localparam logic [3:0] PWLS_REG_TRI_LO   = 4'd2;
  localparam logic [3:0] PWLS_REG_TRI_HI   = 4'd3;
  localparam logic [3:0] PWLS_REG_SLOPE_LO = 4'd4;
  localparam logic [3:0] PWLS_REG_SLOPE_HI = 4'd5;
  localparam logic [3:0] PWLS_REG_AMP_LO   = 4'd6;
  localparam logic [3:0] PWLS_REG_AMP_HI   = 4'd7;
  localparam logic [3:0] PWLS_REG_CMD      = 4'd8;

  localparam int PWLS_CMD_COMMIT_BIT = 0;
  localparam int PWLS_CMD_FORCE_BIT  = 1;

  typedef enum logic {
    PWLS_ST_IDLE    = 1'b0,
    PWLS_ST_PENDING = 1'b1
  } pwls_state_e;

endpackage

// File: rtl/pwls_channel_reg_writer.sv
// Byte-wide host writer for one channel's ALU parameters; shadow set is applied atomically
// on a sample boundary (commit) or immediately (force). Writes stall while a commit is pending.
module pwls_channel_reg_writer
  import pwls_pkg::*;
#(
  parameter int BITS            = 12,
  parameter int OCT_BITS        = 3,
  parameter int MANTISSA_BITS   = 10,
  parameter int DETUNE_EXP_BITS = 3,
  parameter int SLOPE_EXP_BITS  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [3:0]                   wr_addr,
  input  logic [7:0]                   wr_data,
  input  logic                         sample_tick,
  output logic [OCT_BITS-1:0]          octave,
  output logic [MANTISSA_BITS-1:0]     mantissa,
  output logic [DETUNE_EXP_BITS-1:0]   detune_exp,
  output logic [BITS-1:0]              tri_offset,
  output logic [SLOPE_EXP_BITS-1:0]    slope_exp,
  output logic [BITS-4:0]              slope_offset,
  output logic [BITS-3:0]              amp,
  output logic [CHANNEL_MODE_BITS-1:0] channel_mode,
  output logic                         commit_pending,
  output logic                         applied
);

  // The byte map below hard-codes field positions for this exact parameter set.
  if (BITS != 12 || OCT_BITS != 3 || MANTISSA_BITS != 10 || DETUNE_EXP_BITS != 3 ||
      SLOPE_EXP_BITS != 4 || CHANNEL_MODE_BITS < 1 || CHANNEL_MODE_BITS > 7) begin : g_bad_params
    $error("pwls_channel_reg_writer: unsupported parameter set");
  end

  pwls_state_e r_state;

  logic [OCT_BITS-1:0]          r_sh_octave;
  logic [MANTISSA_BITS-1:0]     r_sh_mantissa;
  logic [DETUNE_EXP_BITS-1:0]   r_sh_detune_exp;
  logic [BITS-1:0]              r_sh_tri_offset;
  logic [SLOPE_EXP_BITS-1:0]    r_sh_slope_exp;
  logic [BITS-4:0]              r_sh_slope_offset;
  logic [BITS-3:0]              r_sh_amp;
  logic [CHANNEL_MODE_BITS-1:0] r_sh_channel_mode;

  logic w_accept;
  logic w_cmd_wr;
  logic w_force;
  logic w_commit;
  logic w_load;

  assign wr_ready       = (r_state == PWLS_ST_IDLE);
  assign commit_pending = (r_state == PWLS_ST_PENDING);

  assign w_accept = wr_valid && wr_ready;
  assign w_cmd_wr = w_accept && (wr_addr == PWLS_REG_CMD);
  assign w_force  = w_cmd_wr && wr_data[PWLS_CMD_FORCE_BIT];
  assign w_commit = w_cmd_wr && wr_data[PWLS_CMD_COMMIT_BIT] && !wr_data[PWLS_CMD_FORCE_BIT];
  // A tick in PENDING is the only non-force load; w_force already implies IDLE via wr_ready.
  assign w_load   = w_force || (commit_pending && sample_tick);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sh_octave       <= '0;
      r_sh_mantissa     <= '0;
      r_sh_detune_exp   <= '0;
      r_sh_tri_offset   <= '0;
      r_sh_slope_exp    <= '0;
      r_sh_slope_offset <= '0;
      r_sh_amp          <= '1;
      r_sh_channel_mode <= '0;
    end else if (w_accept) begin
      case (wr_addr)
        PWLS_REG_MANT_LO:  r_sh_mantissa[7:0] <= wr_data;
        PWLS_REG_MANT_HI: begin
          r_sh_mantissa[9:8] <= wr_data[1:0];
          r_sh_octave        <= wr_data[4:2];
          r_sh_detune_exp    <= wr_data[7:5];
        end
        PWLS_REG_TRI_LO:   r_sh_tri_offset[7:0] <= wr_data;
        PWLS_REG_TRI_HI: begin
          r_sh_tri_offset[11:8] <= wr_data[3:0];
          r_sh_slope_exp        <= wr_data[7:4];
        end
        PWLS_REG_SLOPE_LO: r_sh_slope_offset[7:0] <= wr_data;
        PWLS_REG_SLOPE_HI: begin
          r_sh_slope_offset[8] <= wr_data[0];
          r_sh_channel_mode    <= wr_data[CHANNEL_MODE_BITS:1];
        end
        PWLS_REG_AMP_LO:   r_sh_amp[7:0] <= wr_data;
        PWLS_REG_AMP_HI:   r_sh_amp[9:8] <= wr_data[1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= PWLS_ST_IDLE;
      applied      <= 1'b0;
      octave       <= '0;
      mantissa     <= '0;
      detune_exp   <= '0;
      tri_offset   <= '0;
      slope_exp    <= '0;
      slope_offset <= '0;
      amp          <= '1;
      channel_mode <= '0;
    end else begin
      applied <= w_load;
      case (r_state)
        PWLS_ST_IDLE:    if (w_commit) r_state <= PWLS_ST_PENDING;
        PWLS_ST_PENDING: if (sample_tick) r_state <= PWLS_ST_IDLE;
        default:         r_state <= PWLS_ST_IDLE;
      endcase
      if (w_load) begin
        octave       <= r_sh_octave;
        mantissa     <= r_sh_mantissa;
        detune_exp   <= r_sh_detune_exp;
        tri_offset   <= r_sh_tri_offset;
        slope_exp    <= r_sh_slope_exp;
        slope_offset <= r_sh_slope_offset;
        amp          <= r_sh_amp;
        channel_mode <= r_sh_channel_mode;
      end
    end
  end

endmodule

// File: doc/pwls_channel_reg_writer.md
Name: pwls_channel_reg_writer

Overview:
- Host-side writer for one synth channel's parameter set; drives the parameter inputs of pwls_channel_ALU_unit.
- Accepts byte writes over a valid/ready handshake into shadow registers.
- On a commit command, transfers the whole shadow set to the output registers atomically at a sample boundary (sample_tick), so the ALU never sees a half-updated parameter set.

Parameters:
- BITS, 12, ALU sample width.
- OCT_BITS, 3, octave width.
- MANTISSA_BITS, 10, mantissa width.
- DETUNE_EXP_BITS, 3, detune exponent width.
- SLOPE_EXP_BITS, 4, slope exponent width.
- The register map below is defined for the default values only. Any other value is an elaboration error.

Ports:
- clk  in  1  clock.
- reset  in  1  reset; asynchronous, active-high.
- wr_valid  in  1  write request.
- wr_ready  out  1  writer can accept a write.
- wr_addr  in  4  byte register address.
- wr_data  in  8  write data.
- sample_tick  in  1  one-cycle pulse marking a sample boundary.
- octave  out  OCT_BITS  to ALU.
- mantissa  out  MANTISSA_BITS  to ALU.
- detune_exp  out  DETUNE_EXP_BITS  to ALU.
- tri_offset  out  BITS  to ALU.
- slope_exp  out  SLOPE_EXP_BITS  to ALU.
- slope_offset  out  BITS-3  to ALU.
- amp  out  BITS-2  to ALU.
- channel_mode  out  CHANNEL_MODE_BITS  to ALU.
- commit_pending  out  1  commit waiting for sample_tick.
- applied  out  1  one-cycle pulse after the outputs have been loaded.

Behaviour:
- Transfer occurs when wr_valid && wr_ready on a rising clk edge.
- wr_ready = 1 in IDLE and 0 in PENDING (combinational from state). wr_valid may be held high; the write is accepted once ready returns.
- Register map (shadow registers; little-endian byte split):
  - 0: mantissa[7:0].
  - 1: [1:0] mantissa[9:8]; [4:2] octave; [7:5] detune_exp.
  - 2: tri_offset[7:0].
  - 3: [3:0] tri_offset[11:8]; [7:4] slope_exp.
  - 4: slope_offset[7:0].
  - 5: [0] slope_offset[8]; [CHANNEL_MODE_BITS:1] channel_mode. CHANNEL_MODE_BITS must be ≤ 7. Remaining bits are ignored.
  - 6: amp[7:0].
  - 7: [1:0] amp[9:8].
  - 8: command. bit0 = commit; bit1 = force (apply immediately, ignore sample_tick). Both bits 0 = no-op.
  - 9-15: write accepted, no effect.
- A shadow write takes effect at the accepting edge. Outputs are unchanged by shadow writes.
- FSM states: IDLE, PENDING.
  - IDLE: accepted write to addr 8 with bit1 = 1 copies shadow to outputs at that edge; state stays IDLE; applied = 1 for the next cycle. bit1 has priority over bit0.
  - IDLE: accepted write to addr 8 with bit0 = 1 and bit1 = 0 moves to PENDING. sample_tick in that same cycle is ignored.
  - PENDING: at the edge where sample_tick = 1, copy shadow to outputs, return to IDLE; applied = 1 for the next cycle.
  - PENDING: shadow cannot change, because wr_ready = 0.
- Outputs
  - commit_pending = (state == PENDING).
  - applied is registered.
  - Output latency: commit + tick takes effect on the tick edge; force takes effect on the write edge.
- Reset (async, any time, including mid-PENDING):
  - state = IDLE, applied = 0.
  - All shadow and output fields = 0, except shadow and output amp = all ones.
  - Pending commit is discarded.

Decomposition:
- Shared package pwls_pkg holds:
  - register address constants (PWLS_REG_MANT_LO … PWLS_REG_CMD);
  - command bit positions;
  - FSM state enum;
  - CHANNEL_MODE_BITS, as the existing shared define.
- No sub-module is needed. Shadow registers, output registers and the FSM live in one module.

Test Plan:
- Reset: assert reset mid-cycle with no clk edge → outputs immediately 0, amp = 10'h3FF, wr_ready = 1, commit_pending = 0.
- Write addr 0 = 8'h34, addr 1 = 8'hA6 (mantissa[9:8] = 2, octave = 1, detune_exp = 5), then commit (addr 8 = 1) → outputs unchanged and wr_ready = 0 until sample_tick; at the tick edge mantissa = 10'h234, octave = 1, detune_exp = 5; applied is high for exactly one cycle; wr_ready returns to 1.
- Commit accepted in the same cycle as sample_tick → no apply on that tick; apply occurs on the next tick 10 cycles later.
- In PENDING, hold wr_valid with addr 6 = 8'h00 → no transfer until after the tick; the committed amp keeps its old value; the addr 6 write lands in shadow afterwards and reaches the outputs only after a second commit.
- Write tri_offset = 12'hABC (addr 2 = 8'hBC, addr 3 = 8'h?A) then force (addr 8 = 2'b11) → tri_offset = 12'hABC at the write edge, no PENDING, applied pulses.
- Assert reset during PENDING → state IDLE, outputs at reset values, and a later sample_tick produces no applied pulse.
